sv_uart_tx_arbiter: RTL and testbench

Shares one sv_uart_engine transmit port (s_axis, DATA_WIDTH words) between N_CH AXI-stream requesters. Arbitration is round-robin and packet-locked: once a channel is granted, it keeps the engine until its tlast beat or until an idle timeout expires. The block sits directly in front of the engine's s_axis port. The engine's RX path bypasses it.

---
 rtl/sv_uart_pkg.sv | 20 ++
 rtl/sv_uart_rr_arbiter.sv | 37 +++
 rtl/sv_uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_sv_uart_tx_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sv_uart_pkg.sv
// Shared types and constants for the sv_uart transmit-side arbiter.
// Provides the arbiter state encoding, the channel-id header tag and
// a helper that sizes channel-id fields.
package sv_uart_pkg;

    // Upper bits of the optional per-packet header byte; low bits carry the channel id.
    localparam logic [7:0] ARB_HDR_TAG = 8'hC0;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_HDR,
        ARB_LOCK
    } arb_state_t;

    // Width of a channel-id field; never narrower than one bit.
    function automatic int arb_id_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/sv_uart_rr_arbiter.sv
// Combinational round-robin pick: returns the first requesting channel
// found when searching upward from ilast+1, wrapping at N_CH.
module sv_uart_rr_arbiter
    import sv_uart_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int IDW = arb_id_width(N_CH)
) (
    input  logic [N_CH-1:0] ireq,
    input  logic [IDW-1:0]  ilast,
    output logic [IDW-1:0]  ogrant,
    output logic            oany
);

    // Candidate k is the channel k+1 positions after the last grant.
    logic [IDW-1:0] cand_idx [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_cand
            assign cand_idx[gi] = IDW'((int'(ilast) + gi + 1) % N_CH);
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest requester wins.
    always_comb begin
        ogrant = '0;
        oany   = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (ireq[cand_idx[k]]) begin
                ogrant = cand_idx[k];
                oany   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sv_uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART engine s_axis
// transmit port among N_CH AXI-stream requesters. A granted channel
// keeps the engine until its tlast beat or an idle timeout.
// Optional feature: define SV_UART_ARB_ID_HEADER_EN to emit a header word
// {0xC0 | id, zeros} to the engine before each granted packet.
module sv_uart_tx_arbiter
    import sv_uart_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 24
) (
    input  logic                       iclk,
    input  logic                       irst,
    input  logic [N_CH*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [N_CH-1:0]            s_axis_tvalid,
    input  logic [N_CH-1:0]            s_axis_tlast,
    output logic [N_CH-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    input  logic [15:0]                itimeout,
    output logic [$clog2(N_CH)-1:0]    ogrant_id,
    output logic                       ogrant_vld,
    output logic                       otimeout
);

    localparam int IDW = $clog2(N_CH);

    arb_state_t      state_reg, state_next;
    logic [IDW-1:0]  grant_id_reg, grant_id_next;
    logic [IDW-1:0]  last_grant_reg, last_grant_next;
    logic            grant_vld_reg, grant_vld_next;
    logic [15:0]     cnt_reg, cnt_next, cnt_inc;

    logic [DATA_WIDTH-1:0] tdata_ch [N_CH];
    logic [IDW-1:0]        pick_id;
    logic                  pick_any;
    logic                  cur_valid;
    logic                  cur_last;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign tdata_ch[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    sv_uart_rr_arbiter #(
        .N_CH   (N_CH)
    ) u_rr (
        .ireq   (s_axis_tvalid),
        .ilast  (last_grant_reg),
        .ogrant (pick_id),
        .oany   (pick_any)
    );

    assign cur_valid  = s_axis_tvalid[grant_id_reg];
    assign cur_last   = s_axis_tlast[grant_id_reg];
    assign cnt_inc    = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
    assign ogrant_id  = grant_id_reg;
    assign ogrant_vld = grant_vld_reg;

    // Next-state, grant bookkeeping and the stream multiplexer.
    always_comb begin
        state_next      = state_reg;
        grant_id_next   = grant_id_reg;
        grant_vld_next  = grant_vld_reg;
        last_grant_next = last_grant_reg;
        cnt_next        = cnt_reg;
        m_axis_tdata    = '0;
        m_axis_tvalid   = 1'b0;
        s_axis_tready   = '0;
        otimeout        = 1'b0;

        case (state_reg)
            ARB_IDLE: begin
                cnt_next = '0;
                if (pick_any) begin
                    grant_id_next  = pick_id;
                    grant_vld_next = 1'b1;
`ifdef SV_UART_ARB_ID_HEADER_EN
                    state_next     = ARB_HDR;
`else
                    state_next     = ARB_LOCK;
`endif
                end
            end
`ifdef SV_UART_ARB_ID_HEADER_EN
            ARB_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {ARB_HDR_TAG | 8'(grant_id_reg), {(DATA_WIDTH-8){1'b0}}};
                if (m_axis_tready) begin
                    state_next = ARB_LOCK;
                end
            end
`endif
            ARB_LOCK: begin
                m_axis_tdata                = tdata_ch[grant_id_reg];
                m_axis_tvalid               = cur_valid;
                s_axis_tready[grant_id_reg] = m_axis_tready;
                if (cur_valid && m_axis_tready) begin
                    // A beat always wins over a coincident timeout.
                    cnt_next = '0;
                    if (cur_last) begin
                        state_next      = ARB_IDLE;
                        last_grant_next = grant_id_reg;
                        grant_vld_next  = 1'b0;
                    end
                end else begin
                    // Only cycles with the holder's tvalid low count as idle.
                    cnt_next = cur_valid ? cnt_reg : cnt_inc;
                    if ((itimeout != 16'd0) && (cnt_next >= itimeout)) begin
                        state_next      = ARB_IDLE;
                        last_grant_next = grant_id_reg;
                        grant_vld_next  = 1'b0;
                        cnt_next        = '0;
                        otimeout        = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase

        // Reset takes the stream interface quiet in the same cycle.
        if (irst) begin
            m_axis_tvalid = 1'b0;
            s_axis_tready = '0;
            otimeout      = 1'b0;
        end
    end

    // State and grant registers with synchronous reset.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_reg      <= ARB_IDLE;
            grant_id_reg   <= '0;
            last_grant_reg <= IDW'(N_CH - 1);
            grant_vld_reg  <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            grant_id_reg   <= grant_id_next;
            last_grant_reg <= last_grant_next;
            grant_vld_reg  <= grant_vld_next;
            cnt_reg        <= cnt_next;
        end
    end

endmodule

// File: tb/tb_sv_uart_tx_arbiter.sv
// Self-checking bench for sv_uart_tx_arbiter (N_CH=4, DATA_WIDTH=24).
// Directed scenarios plus randomized traffic checked against a
// packet-level round-robin model. The header scenario runs only when
// SV_UART_ARB_ID_HEADER_EN is defined.
module tb_sv_uart_tx_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 24;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NCH*DW-1:0] s_tdata = '0;
    logic [NCH-1:0]  s_tvalid = '0;
    logic [NCH-1:0]  s_tlast = '0;
    logic [NCH-1:0]  s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready = 1'b0;
    logic [15:0]     tmo = 16'd0;
    logic [1:0]      gid;
    logic            gvld;
    logic            tout;

    int errors = 0;
    int checks = 0;

    sv_uart_tx_arbiter #(.N_CH(NCH), .DATA_WIDTH(DW)) dut (
        .iclk          (clk),
        .irst          (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .itimeout      (tmo),
        .ogrant_id     (gid),
        .ogrant_vld    (gvld),
        .otimeout      (tout)
    );

    always #5 clk = ~clk;

    // Round-robin rule: first requester searching upward from last+1, wrapping.
    function automatic int rr_pick(input logic [NCH-1:0] req, input int last);
        for (int k = 1; k <= NCH; k++) begin
            if (req[(last + k) % NCH]) return (last + k) % NCH;
        end
        return -1;
    endfunction

    task automatic drive(input int ch, input logic [DW-1:0] d, input logic v, input logic l);
        s_tdata[ch*DW +: DW] = d;
        s_tvalid[ch]         = v;
        s_tlast[ch]          = l;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0; tmo = 16'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_tvalid = '1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %0b expected 0", m_tvalid); end
        checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL reset_s_tready: got %b expected 0000", s_tready); end
        checks++; if (gvld !== 1'b0) begin errors++; $display("FAIL reset_grant_vld: got %0b expected 0", gvld); end
        checks++; if (gid !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", gid); end
        checks++; if (tout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b expected 0", tout); end
        @(negedge clk);
        s_tvalid = '0; rst = 1'b0;
        #1;
        checks++; if (gvld !== 1'b0) begin errors++; $display("FAIL reset_idle: got %0b expected 0", gvld); end
        $display("reset: outputs quiet");
    endtask

    task automatic test_single();
        logic [DW-1:0] words [3];
        words[0] = 24'h112233; words[1] = 24'h445566; words[2] = 24'h778899;
        do_reset();
        m_tready = 1'b1;
        drive(0, words[0], 1'b1, 1'b0);
        #1;
        checks++; if (gvld !== 1'b0 || s_tready !== 4'b0000) begin errors++; $display("FAIL single_arb_cycle: got vld=%0b rdy=%b expected vld=0 rdy=0000", gvld, s_tready); end
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            drive(0, words[w], 1'b1, (w == 2));
            #1;
            checks++; if (gvld !== 1'b1 || gid !== 2'd0) begin errors++; $display("FAIL single_grant: got vld=%0b id=%0d expected vld=1 id=0", gvld, gid); end
            checks++; if (m_tvalid !== 1'b1 || m_tdata !== words[w]) begin errors++; $display("FAIL single_word%0d: got v=%0b d=%h expected v=1 d=%h", w, m_tvalid, m_tdata, words[w]); end
            checks++; if (s_tready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", s_tready); end
            $display("single: beat %0d data %h", w, m_tdata);
        end
        @(negedge clk);
        drive(0, '0, 1'b0, 1'b0);
        #1;
        checks++; if (gvld !== 1'b0) begin errors++; $display("FAIL single_release: got %0b expected 0", gvld); end
    endtask

    task automatic test_rr();
        int exp_order [5];
        int seq [NCH];
        int k = 0;
        int last_cyc = 0;
        logic [DW-1:0] exp_d;
        exp_order = '{0, 1, 2, 3, 0};
        for (int c = 0; c < NCH; c++) seq[c] = 0;
        do_reset();
        m_tready = 1'b1;
        for (int cyc = 0; cyc < 30 && k < 5; cyc++) begin
            if (cyc > 0) @(negedge clk);
            for (int c = 0; c < NCH; c++) drive(c, 24'(c * 65536 + seq[c]), 1'b1, 1'b1);
            #1;
            if (m_tvalid && m_tready) begin
                exp_d = 24'(exp_order[k] * 65536 + seq[exp_order[k]]);
                checks++; if (gid !== 2'(exp_order[k])) begin errors++; $display("FAIL rr_order%0d: got ch%0d expected ch%0d", k, gid, exp_order[k]); end
                checks++; if (m_tdata !== exp_d) begin errors++; $display("FAIL rr_data%0d: got %h expected %h", k, m_tdata, exp_d); end
                checks++; if (s_tready !== (4'b0001 << exp_order[k])) begin errors++; $display("FAIL rr_ready%0d: got %b expected %b", k, s_tready, 4'b0001 << exp_order[k]); end
                if (k > 0) begin
                    checks++; if (cyc - last_cyc != 2) begin errors++; $display("FAIL rr_gap%0d: got %0d cycles expected 2", k, cyc - last_cyc); end
                end
                $display("rr: packet %0d from ch%0d data %h", k, gid, m_tdata);
                last_cyc = cyc;
                seq[exp_order[k]]++;
                k++;
            end
        end
        checks++; if (k != 5) begin errors++; $display("FAIL rr_count: got %0d packets expected 5", k); end
        @(negedge clk);
        s_tvalid = '0; s_tlast = '0;
        @(negedge clk);
    endtask

    task automatic test_lock();
        int idx = 0;
        int last_beat_cyc = -1;
        bit ch1_done = 0;
        m_tready = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc > 0) @(negedge clk);
            drive(2, 24'(24'h200000 + idx), (idx < 4) && (cyc != 3) && (cyc != 4), (idx == 3));
            drive(1, 24'hA1A1A1, (cyc >= 1) && !ch1_done, 1'b1);
            #1;
            if (cyc >= 1 && idx < 4) begin
                checks++; if (s_tready[1] !== 1'b0) begin errors++; $display("FAIL lock_ch1_ready c%0d: got %0b expected 0", cyc, s_tready[1]); end
                checks++; if (gvld !== 1'b1 || gid !== 2'd2) begin errors++; $display("FAIL lock_hold c%0d: got vld=%0b id=%0d expected vld=1 id=2", cyc, gvld, gid); end
            end
            if (s_tvalid[2] && s_tready[2]) begin
                checks++; if (m_tdata !== 24'(24'h200000 + idx)) begin errors++; $display("FAIL lock_data%0d: got %h expected %h", idx, m_tdata, 24'(24'h200000 + idx)); end
                $display("lock: ch2 beat %0d data %h", idx, m_tdata);
                if (idx == 3) last_beat_cyc = cyc;
                idx++;
            end else if (s_tvalid[1] && s_tready[1]) begin
                checks++; if (gid !== 2'd1 || m_tdata !== 24'hA1A1A1) begin errors++; $display("FAIL lock_next: got id=%0d d=%h expected id=1 d=a1a1a1", gid, m_tdata); end
                checks++; if (cyc != last_beat_cyc + 2) begin errors++; $display("FAIL lock_next_latency: got cycle %0d expected %0d", cyc, last_beat_cyc + 2); end
                $display("lock: ch1 beat data %h", m_tdata);
                ch1_done = 1;
            end
        end
        checks++; if (idx != 4 || !ch1_done) begin errors++; $display("FAIL lock_complete: got ch2 beats=%0d ch1=%0b expected 4 and 1", idx, ch1_done); end
        @(negedge clk);
        s_tvalid = '0; s_tlast = '0;
    endtask

    task automatic test_timeout();
        do_reset();
        m_tready = 1'b1;
        tmo = 16'd10;
        drive(1, 24'h100001, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        checks++; if (gid !== 2'd1 || m_tvalid !== 1'b1 || m_tdata !== 24'h100001) begin errors++; $display("FAIL tmo_first: got id=%0d v=%0b d=%h expected id=1 v=1 d=100001", gid, m_tvalid, m_tdata); end
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            drive(1, 24'h100002, 1'b0, 1'b0);
            drive(2, 24'h200002, 1'b1, 1'b1);
            #1;
            if (i <= 10) begin
                checks++; if (tout !== (i == 10)) begin errors++; $display("FAIL tmo_pulse i%0d: got %0b expected %0b", i, tout, (i == 10)); end
                checks++; if (gvld !== 1'b1 || s_tready[2] !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL tmo_hold i%0d: got vld=%0b rdy2=%0b mv=%0b expected 1 0 0", i, gvld, s_tready[2], m_tvalid); end
            end else if (i == 11) begin
                checks++; if (gvld !== 1'b0 || tout !== 1'b0) begin errors++; $display("FAIL tmo_release: got vld=%0b tout=%0b expected 0 0", gvld, tout); end
            end else begin
                checks++; if (gvld !== 1'b1 || gid !== 2'd2 || m_tdata !== 24'h200002) begin errors++; $display("FAIL tmo_next: got vld=%0b id=%0d d=%h expected 1 2 200002", gvld, gid, m_tdata); end
                $display("timeout: abort after 10 idle cycles, next grant ch%0d", gid);
            end
        end
        @(negedge clk);
        s_tvalid = '0; s_tlast = '0; tmo = 16'd0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        m_tready = 1'b1;
        drive(3, 24'h300000, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < NCH; c++) drive(c, 24'(c), 1'b1, 1'b0);
        #1;
        checks++; if (gvld !== 1'b1 || gid !== 2'd3) begin errors++; $display("FAIL rmid_locked: got vld=%0b id=%0d expected 1 3", gvld, gid); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (s_tready !== 4'b0000 || m_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_quiet: got rdy=%b mv=%0b expected 0000 0", s_tready, m_tvalid); end
        @(negedge clk);
        #1;
        checks++; if (gvld !== 1'b0 || gid !== 2'd0 || s_tready !== 4'b0000 || m_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_reset: got vld=%0b id=%0d rdy=%b mv=%0b expected 0 0 0000 0", gvld, gid, s_tready, m_tvalid); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (gvld !== 1'b0) begin errors++; $display("FAIL rmid_idle: got %0b expected 0", gvld); end
        @(negedge clk);
        #1;
        checks++; if (gvld !== 1'b1 || gid !== 2'd0) begin errors++; $display("FAIL rmid_first: got vld=%0b id=%0d expected 1 0", gvld, gid); end
        $display("reset mid-packet: first grant after reset ch%0d", gid);
        @(negedge clk);
        s_tvalid = '0; s_tlast = '0;
    endtask

    task automatic test_random();
        int rem [NCH];
        logic [DW-1:0] wd [NCH];
        bit wl [NCH];
        bit pend [NCH];
        int cur = 0;
        int last_g = NCH - 1;
        logic [NCH-1:0] prev_v = '0;
        bit prev_gv = 0;
        bit prev_end = 0;
        logic [NCH-1:0] exp_rdy;
        int npkt = 0;
        for (int c = 0; c < NCH; c++) begin rem[c] = 0; wd[c] = '0; wl[c] = 0; pend[c] = 0; end
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc > 0) @(negedge clk);
            m_tready = ($urandom_range(0, 9) < 7);
            for (int c = 0; c < NCH; c++) begin
                if (!pend[c]) begin
                    if (rem[c] == 0 && $urandom_range(0, 3) == 0) rem[c] = $urandom_range(1, 4);
                    if (rem[c] > 0 && $urandom_range(0, 1) == 1) begin
                        pend[c] = 1; wd[c] = DW'($urandom); wl[c] = (rem[c] == 1);
                    end
                end
                drive(c, wd[c], pend[c], wl[c]);
            end
            #1;
            if (!prev_gv) begin
                checks++; if (gvld !== (prev_v != 0)) begin errors++; $display("FAIL rnd_latency c%0d: got vld=%0b expected %0b", cyc, gvld, (prev_v != 0)); end
                if (gvld && prev_v != 0) begin
                    cur = rr_pick(prev_v, last_g);
                    checks++; if (gid !== 2'(cur)) begin errors++; $display("FAIL rnd_pick c%0d: got ch%0d expected ch%0d", cyc, gid, cur); end
                end
            end else begin
                checks++; if (gvld !== !prev_end) begin errors++; $display("FAIL rnd_lock c%0d: got vld=%0b expected %0b", cyc, gvld, !prev_end); end
            end
            prev_end = 0;
            if (gvld && !(prev_gv && prev_end)) begin
                exp_rdy = '0; exp_rdy[cur] = m_tready;
                checks++; if (s_tready !== exp_rdy || m_tvalid !== pend[cur]) begin errors++; $display("FAIL rnd_mux c%0d: got rdy=%b mv=%0b expected %b %0b", cyc, s_tready, m_tvalid, exp_rdy, pend[cur]); end
                if (pend[cur]) begin
                    checks++; if (m_tdata !== wd[cur]) begin errors++; $display("FAIL rnd_data c%0d: got %h expected %h", cyc, m_tdata, wd[cur]); end
                end
                if (pend[cur] && m_tready && wl[cur]) begin
                    prev_end = 1; last_g = cur; npkt++;
                    $display("random: packet %0d from ch%0d ends at cycle %0d", npkt, cur, cyc);
                end
            end else begin
                checks++; if (s_tready !== 4'b0000 || m_tvalid !== 1'b0) begin errors++; $display("FAIL rnd_idle c%0d: got rdy=%b mv=%0b expected 0000 0", cyc, s_tready, m_tvalid); end
            end
            for (int c = 0; c < NCH; c++) begin
                if (pend[c] && s_tready[c]) begin pend[c] = 0; rem[c]--; end
            end
            prev_v  = s_tvalid;
            prev_gv = gvld;
        end
        checks++; if (npkt < 20) begin errors++; $display("FAIL rnd_progress: got %0d packets expected at least 20", npkt); end
        @(negedge clk);
        s_tvalid = '0; s_tlast = '0;
    endtask

`ifdef SV_UART_ARB_ID_HEADER_EN
    task automatic test_header();
        do_reset();
        m_tready = 1'b1;
        drive(3, 24'h123456, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        checks++; if (m_tvalid !== 1'b1 || m_tdata !== 24'hC30000 || s_tready !== 4'b0000) begin errors++; $display("FAIL hdr_word: got v=%0b d=%h rdy=%b expected 1 c30000 0000", m_tvalid, m_tdata, s_tready); end
        $display("header: word %h", m_tdata);
        @(negedge clk);
        #1;
        checks++; if (m_tdata !== 24'h123456 || s_tready !== 4'b1000) begin errors++; $display("FAIL hdr_payload: got d=%h rdy=%b expected 123456 1000", m_tdata, s_tready); end
        $display("header: payload %h", m_tdata);
        @(negedge clk);
        s_tvalid = '0; s_tlast = '0;
    endtask
`endif

    initial begin
        test_reset();
`ifdef SV_UART_ARB_ID_HEADER_EN
        test_header();
`else
        test_single();
        test_rr();
        test_lock();
        test_timeout();
        test_reset_mid();
        test_random();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
